// File: rtl/sprite_motion.sv
// Per-sprite offset animator: a frame tick from a synchronised vsync drives
// independent delay/move/loop/bounce channels, each reconfigurable by a write strobe.

module sprite_motion_lane #(
  parameter int POS_W = 12,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    we,
  input  logic signed [POS_W-1:0] cfg_hstart,
  input  logic signed [POS_W-1:0] cfg_vstart,
  input  logic signed [POS_W-1:0] cfg_hstep,
  input  logic signed [POS_W-1:0] cfg_vstep,
  input  logic [CNT_W-1:0]        cfg_delay,
  input  logic [CNT_W-1:0]        cfg_frames,
  input  logic [1:0]              cfg_mode,
  output logic signed [POS_W-1:0] hoff,
  output logic signed [POS_W-1:0] voff,
  output logic                    busy,
  output logic                    done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_MOVE  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_LOOP   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_HOLD   = 2'd3;

  logic [1:0]              st, mode;
  logic [CNT_W-1:0]        cnt, frames;
  logic signed [POS_W-1:0] hstart, vstart, hstep, vstep;
  logic signed [POS_W-1:0] hnext, vnext;

  assign hnext = hoff + hstep;
  assign vnext = voff + vstep;
  assign busy  = (st == S_DELAY) || (st == S_MOVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      mode   <= 2'd0;
      cnt    <= '0;
      frames <= '0;
      hstart <= '0;
      vstart <= '0;
      hstep  <= '0;
      vstep  <= '0;
      hoff   <= '0;
      voff   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      // A write wins over a coincident tick: start offsets load, no step applied.
      if (we) begin
        hoff   <= cfg_hstart;
        voff   <= cfg_vstart;
        hstart <= cfg_hstart;
        vstart <= cfg_vstart;
        hstep  <= cfg_hstep;
        vstep  <= cfg_vstep;
        mode   <= cfg_mode;
        frames <= cfg_frames;
        if (cfg_mode == M_HOLD || cfg_frames == '0) begin
          st   <= S_DONE;
          done <= 1'b1;
        end else if (cfg_delay != '0) begin
          st  <= S_DELAY;
          cnt <= cfg_delay;
        end else begin
          st  <= S_MOVE;
          cnt <= cfg_frames;
        end
      end else if (tick) begin
        case (st)
          S_DELAY: begin
            if (cnt == CNT_W'(1)) begin
              st  <= S_MOVE;
              cnt <= frames;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_MOVE: begin
            if (cnt == CNT_W'(1)) begin
              case (mode)
                M_LOOP: begin
                  hoff <= hstart;
                  voff <= vstart;
                  cnt  <= frames;
                end
                M_BOUNCE: begin
                  hoff  <= hnext;
                  voff  <= vnext;
                  hstep <= -hstep;
                  vstep <= -vstep;
                  cnt   <= frames;
                end
                default: begin
                  hoff <= hnext;
                  voff <= vnext;
                  st   <= S_DONE;
                  done <= 1'b1;
                end
              endcase
            end else begin
              hoff <= hnext;
              voff <= vnext;
              cnt  <= cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

module sprite_motion #(
  parameter int NUM_SPRITES = 4,
  parameter int POS_W       = 12,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic                          vsync,
  input  logic                          pause,
  input  logic                          cfg_we,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [POS_W-1:0]              cfg_hstart,
  input  logic [POS_W-1:0]              cfg_vstart,
  input  logic [POS_W-1:0]              cfg_hstep,
  input  logic [POS_W-1:0]              cfg_vstep,
  input  logic [CNT_W-1:0]              cfg_delay,
  input  logic [CNT_W-1:0]              cfg_frames,
  input  logic [1:0]                    cfg_mode,
  output logic [NUM_SPRITES*POS_W-1:0]  hoffset,
  output logic [NUM_SPRITES*POS_W-1:0]  voffset,
  output logic [NUM_SPRITES-1:0]        busy,
  output logic [NUM_SPRITES-1:0]        done,
  output logic                          frame_tick
);
  localparam int STAGES = 2;

  logic [2:0]                          vs_sync;
  logic [STAGES:0]                     vld_pipe;
  logic                                tick;
  logic [NUM_SPRITES-1:0][POS_W-1:0]   hoff_l, voff_l;

  // vld_pipe masks edges until the synchroniser has refilled after reset, so a
  // vsync already high at release is not mistaken for a rising edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vs_sync    <= '0;
      vld_pipe   <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs_sync    <= {vs_sync[1:0], vsync};
      vld_pipe   <= {vld_pipe[STAGES-1:0], 1'b1};
      frame_tick <= vld_pipe[STAGES] & vs_sync[1] & ~vs_sync[2];
    end
  end

  assign tick = frame_tick & ~pause;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
    sprite_motion_lane #(.POS_W(POS_W), .CNT_W(CNT_W)) u_lane (
      .clk        (CLK100MHZ),
      .rst_n      (CPU_RESETN),
      .tick       (tick),
      .we         (cfg_we && (cfg_sel == SEL_W'(i))),
      .cfg_hstart (cfg_hstart),
      .cfg_vstart (cfg_vstart),
      .cfg_hstep  (cfg_hstep),
      .cfg_vstep  (cfg_vstep),
      .cfg_delay  (cfg_delay),
      .cfg_frames (cfg_frames),
      .cfg_mode   (cfg_mode),
      .hoff       (hoff_l[i]),
      .voff       (voff_l[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

  assign hoffset = hoff_l;
  assign voffset = voff_l;
endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: expected offsets/flags are queued per frame
// and popped once the DUT has applied that frame tick.

module tb_sprite_motion;
  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        vsync = 1'b0;
  logic        pause = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [11:0] cfg_hstart = '0, cfg_vstart = '0, cfg_hstep = '0, cfg_vstep = '0;
  logic [7:0]  cfg_delay = '0, cfg_frames = '0;
  logic [1:0]  cfg_mode = '0;
  logic [47:0] hoffset, voffset;
  logic [3:0]  busy, done;
  logic        frame_tick;

  typedef struct {
    string tag;
    int    ch;
    int    h;
    int    v;
    int    dn;
    int    bz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sprite_motion #(.NUM_SPRITES(4), .POS_W(12), .CNT_W(8)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .vsync      (vsync),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_hstart (cfg_hstart),
    .cfg_vstart (cfg_vstart),
    .cfg_hstep  (cfg_hstep),
    .cfg_vstep  (cfg_vstep),
    .cfg_delay  (cfg_delay),
    .cfg_frames (cfg_frames),
    .cfg_mode   (cfg_mode),
    .hoffset    (hoffset),
    .voffset    (voffset),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int hof(input int ch);
    logic signed [11:0] s;
    s = hoffset[ch*12 +: 12];
    return int'(s);
  endfunction

  function automatic int vof(input int ch);
    logic signed [11:0] s;
    s = voffset[ch*12 +: 12];
    return int'(s);
  endfunction

  task automatic push(input string tag, input int ch, input int h, input int v,
                      input int dn, input int bz);
    exp_t e;
    e.tag = tag; e.ch = ch; e.h = h; e.v = v; e.dn = dn; e.bz = bz;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".h"},    hof(e.ch),        e.h);
      check({e.tag, ".v"},    vof(e.ch),        e.v);
      check({e.tag, ".done"}, int'(done[e.ch]), e.dn);
      check({e.tag, ".busy"}, int'(busy[e.ch]), e.bz);
    end
  endtask

  task automatic set_cfg(input int sel, input int hs, input int vs, input int hst,
                         input int vst, input int dly, input int frm, input int mode);
    cfg_sel    = 2'(sel);
    cfg_hstart = 12'(hs);
    cfg_vstart = 12'(vs);
    cfg_hstep  = 12'(hst);
    cfg_vstep  = 12'(vst);
    cfg_delay  = 8'(dly);
    cfg_frames = 8'(frm);
    cfg_mode   = 2'(mode);
  endtask

  task automatic write_cfg();
    cfg_we = 1'b1;
    @(negedge CLK100MHZ);
    cfg_we = 1'b0;
  endtask

  // One vsync pulse; optionally fire the pending config write in the tick cycle.
  task automatic frame(input bit wr);
    bit seen;
    seen = 1'b0;
    vsync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK100MHZ);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_tick_seen", int'(seen), 1);
    cfg_we = wr;
    @(negedge CLK100MHZ);
    cfg_we = 1'b0;
    drain();
    vsync = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
  endtask

  task automatic latency(input string tag);
    int n;
    n = 0;
    vsync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK100MHZ);
      n++;
      if (frame_tick) break;
    end
    check(tag, n, 3);
    @(negedge CLK100MHZ);
    check({tag, "_width"}, int'(frame_tick), 0);
    vsync = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
  endtask

  initial begin
    int flag;
    #1;
    for (int c = 0; c < 4; c++) check("rst_h", hof(c), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(frame_tick), 0);
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    repeat (5) @(negedge CLK100MHZ);
    latency("tick_latency");

    // ONCE with negative vertical step
    set_cfg(0, -200, -40, 1, -6, 0, 3, 0);
    write_cfg();
    push("ch0_f1", 0, -199, -46, 0, 1); frame(1'b0);
    push("ch0_f2", 0, -198, -52, 0, 1); frame(1'b0);
    push("ch0_f3", 0, -197, -58, 1, 0); frame(1'b0);
    check("ch0_done_clear", int'(done[0]), 0);

    // delay of two frames before motion
    set_cfg(1, 0, 0, -300, 0, 2, 2, 0);
    write_cfg();
    push("ch1_f1", 1, 0, 0, 0, 1);    frame(1'b0);
    push("ch1_f2", 1, 0, 0, 0, 1);    frame(1'b0);
    push("ch1_f3", 1, -300, 0, 0, 1); frame(1'b0);
    push("ch1_f4", 1, -600, 0, 1, 0); frame(1'b0);
    push("ch1_f5", 1, -600, 0, 0, 0); frame(1'b0);

    // BOUNCE reverses step at each pass end
    set_cfg(2, 10, 0, 5, 0, 0, 2, 2);
    write_cfg();
    push("ch2_f1", 2, 15, 0, 0, 1); frame(1'b0);
    push("ch2_f2", 2, 20, 0, 0, 1); frame(1'b0);
    push("ch2_f3", 2, 15, 0, 0, 1); frame(1'b0);
    push("ch2_f4", 2, 10, 0, 0, 1); frame(1'b0);
    push("ch2_f5", 2, 15, 0, 0, 1); frame(1'b0);

    // LOOP with a pause window
    set_cfg(3, 0, 0, 100, 0, 0, 2, 1);
    write_cfg();
    push("ch3_f1", 3, 100, 0, 0, 1); frame(1'b0);
    push("ch3_f2", 3, 0, 0, 0, 1);   frame(1'b0);
    pause = 1'b1;
    push("ch3_p1", 3, 0, 0, 0, 1);   frame(1'b0);
    push("ch3_p2", 3, 0, 0, 0, 1);   frame(1'b0);
    push("ch3_p3", 3, 0, 0, 0, 1);   frame(1'b0);
    pause = 1'b0;
    push("ch3_f3", 3, 100, 0, 0, 1); frame(1'b0);
    push("ch3_f4", 3, 0, 0, 0, 1);   frame(1'b0);

    // positive wrap at POS_W
    set_cfg(0, 2047, 0, 1, 0, 0, 1, 0);
    write_cfg();
    push("ch0_wrap", 0, -2048, 0, 1, 0); frame(1'b0);

    // HOLD goes straight to DONE with a pulse
    set_cfg(2, 5, -5, 3, 3, 0, 4, 3);
    write_cfg();
    check("ch2_hold_h", hof(2), 5);
    check("ch2_hold_done", int'(done[2]), 1);
    check("ch2_hold_busy", int'(busy[2]), 0);

    // write coincident with a tick: ch1 loads start only, ch3 steps normally
    set_cfg(3, 0, 0, 100, 0, 0, 2, 1);
    write_cfg();
    set_cfg(1, 123, -7, 7, 1, 0, 5, 1);
    push("ch1_coinc", 1, 123, -7, 0, 1);
    push("ch3_neigh", 3, 100, 0, 0, 1);
    push("ch2_held", 2, 5, -5, 0, 0);
    frame(1'b1);

    // reset mid-MOVE with vsync held high across release
    vsync = 1'b1;
    #2;
    CPU_RESETN = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("arst_h", hof(c), 0);
      check("arst_v", vof(c), 0);
    end
    check("arst_busy", int'(busy), 0);
    flag = 0;
    repeat (3) begin
      @(negedge CLK100MHZ);
      if (done != 4'b0) flag = 1;
    end
    CPU_RESETN = 1'b1;
    repeat (10) begin
      @(negedge CLK100MHZ);
      if (done != 4'b0) flag = flag | 1;
      if (frame_tick) flag = flag | 2;
    end
    check("post_rst_quiet", flag, 0);
    vsync = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
    latency("post_rst_latency");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
